avr_uart_tx: RTL and testbench
==============================

Name: avr_uart_tx

Overview:
- Serial transmitter from the FPGA to the AVR on `avr_rx` (FPGA Tx to AVR Rx), 8N1, LSB first.
- Frames one byte per request and honours the AVR's `avr_rx_busy` flow-control line.
- Instantiated in the top level beside the clock/display logic, so that time and button state can be reported to the host.
- Replaces the current high-Z tie-off of `avr_rx`.

Parameters:
- CLK_PER_BIT, 100, clk cycles per serial bit (50 MHz / 500 kbaud AVR link); legal range ≥ 2.
- CTR_SIZE, $clog2(CLK_PER_BIT), bit-timer width; derived, not overridden.

Ports:
- clk       in   1  system clock, 50 MHz
- rst       in   1  reset, asynchronous, active-high
- data      in   8  byte to send; sampled only on the acceptance cycle
- new_data  in   1  request strobe; one byte per accepted cycle
- block     in   1  AVR Rx buffer full (`avr_rx_busy`); raw, asynchronous to clk
- busy      out  1  high = request will not be accepted this cycle
- tx        out  1  serial line to AVR; idle high

Behaviour:
- Reset values:
  - tx = 1, busy = 1 while rst is held.
  - state = IDLE, bit timer = 0, bit index = 0, shift register = 0, block_q = 1.
  - First cycle after reset release: busy = 1 (block_q not yet refreshed). Thereafter busy = (state != IDLE) | block_q.
- block_q is a single flop sampling `block` every clk edge.
- busy is combinational from registered signals only.
- Acceptance:
  - Occurs at the edge where state == IDLE, block_q == 0 and new_data == 1.
  - At that edge, data is latched into the shift register, state → START, tx → 0.
  - Latency is one clock: request edge to tx falling.
  - new_data while busy == 1 is ignored, not queued.
- States and transitions:
  - IDLE: tx = 1. Go to START on acceptance.
  - START: tx = 0 for CLK_PER_BIT cycles. Then go to DATA with bit index = 0.
  - DATA: tx = shift[bit index] for CLK_PER_BIT cycles per bit. Index 0..7, LSB first. After index 7 expires, go to STOP (or PARITY if the feature is enabled).
  - STOP: tx = 1 for CLK_PER_BIT cycles. Then go to IDLE.
- Frame length: exactly 10 × CLK_PER_BIT cycles (11 × with parity), measured from tx falling to the STOP→IDLE transition.
- Bit timer:
  - Counts 0..CLK_PER_BIT-1.
  - Resets to 0 on every bit boundary and in IDLE.
  - Wraps, never saturates.
- Back-to-back operation: if new_data is high on the first IDLE cycle with block_q == 0, the next start bit begins one cycle after STOP ends. Minimum inter-frame idle is 1 cycle.
- block rising mid-frame: ignored; the current frame completes unmodified. block is only checked in IDLE.
- block and new_data rising in the same cycle: block_q is still 0, so the request is accepted.
- Reset mid-frame: tx returns to 1 asynchronously. The partial frame is abandoned and no retransmit is attempted.
- data changing after acceptance has no effect on the frame in flight.

Optional Feature:
- Macro: AVR_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles.
  - Frame is 11 bit-times.
- When undefined: no PARITY state, no parity logic, 10 bit-time frame.

Decomposition:
- Package `avr_uart_pkg`:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - constants: DATA_BITS = 8, IDLE_LEVEL = 1.
  - default CLK_PER_BIT = 100.
- Sub-module `uart_bit_timer`:
  - Parameter CLK_PER_BIT.
  - Inputs clk, rst, clear; output `tick`, high on the cycle count == CLK_PER_BIT-1.
  - The FSM advances state or bit index only on `tick`.

Test Plan:
- Send 0x55, block = 0, CLK_PER_BIT = 100:
  - tx falls 1 cycle after the request.
  - Bits read 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each exactly 100 cycles.
  - busy high for 1000 cycles, then low.
- block = 1, pulse new_data with 0xA3:
  - busy stays 1 and tx stays 1 for 500 cycles.
  - Drop block: nothing is sent (request dropped).
  - Re-request: 0xA3 frame appears.
- Send 0xFF, raise block at cycle 300:
  - Frame completes intact (start 0, eight 1s, stop 1).
  - busy remains 1 after STOP until block falls.
- Hold new_data high with 0x01 then 0x80 back-to-back:
  - Two frames with exactly 1 idle-high cycle between stop and second start.
  - Data bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Assert rst at cycle 450 of a 0x00 frame:
  - tx = 1 in the same cycle.
  - After release: busy = 1 for 1 cycle, then 0; no residual bits.
- With AVR_UART_TX_PARITY_EN, send 0x07:
  - Parity bit = 1 at bit-time 9.
  - Stop at bit-time 10; total 1100 cycles.

Source files
------------

// File: rtl/avr_uart_tx_pkg.sv
// Shared types and constants for the FPGA-to-AVR serial transmitter.
// The PARITY state exists in the enum always; it is only reachable with AVR_UART_TX_PARITY_EN.
package avr_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DATA_BITS           = 8;
  localparam logic IDLE_LEVEL          = 1'b1;
  localparam int   DEFAULT_CLK_PER_BIT = 100;

endpackage

// File: rtl/avr_uart_tx_if.sv
// Byte request channel into avr_uart_tx.
// Handshake: a byte is taken on a clk edge where new_data == 1 and busy == 0;
// new_data while busy == 1 is dropped, never queued. data matters only on that edge.
interface avr_uart_tx_if;
  logic [7:0] data;
  logic       new_data;
  logic       busy;

  modport master (output data, output new_data, input busy);
  modport slave  (input data, input new_data, output busy);
endinterface

// File: rtl/avr_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 and pulses tick on the last count.
// clear holds the count at zero; the count wraps after every tick.
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CTR_SIZE = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CTR_SIZE-1:0] LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  logic [CTR_SIZE-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CTR_SIZE'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/avr_uart_tx.sv
// 8N1 LSB-first serial transmitter toward the AVR, gated by the AVR's busy line.
// Define AVR_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module avr_uart_tx
  import avr_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic            clk,
  input  logic            rst,
  avr_uart_tx_if.slave    req,
  input  logic            block,
  output logic            tx,
  output state_t          state_dbg
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t                 state, state_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic                   tx_q, tx_d;
  logic                   block_q;
  logic                   tick;

  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // block_q resets high so nothing is accepted until block has been sampled once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shift   <= '0;
      tx_q    <= IDLE_LEVEL;
      block_q <= 1'b1;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
      block_q <= block;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    shift_d = shift;
    unique case (state)
      IDLE: begin
        if (req.new_data && !block_q) begin
          state_d = START;
          shift_d = req.data;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
`ifdef AVR_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    tx_d = IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
`ifdef AVR_UART_TX_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  assign tx        = tx_q;
  assign req.busy  = (state != IDLE) || block_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Scoreboarded bench for avr_uart_tx: a time-based model predicts acceptance and busy,
// and a line monitor reconstructs every frame from tx and checks it bit-time by bit-time.
module tb_avr_uart_tx;
  import avr_uart_pkg::*;

  localparam int CPB = 100;
`ifdef AVR_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int W = 40;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   block = 1'b0;
  logic   tx;
  state_t state_dbg;

  always #5 clk = ~clk;

  avr_uart_tx_if bus ();

  avr_uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.slave),
    .block     (block),
    .tx        (tx),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  int  free_at = 0;
  int  acc_cnt = 0;
  int  frames_done = 0;
  logic mblock_q = 1'b1;

  always @(posedge clk) edge_n <= edge_n + 1;

  // A request is taken when the previous frame's last edge has passed and block was low one edge ago.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mblock_q <= 1'b1;
      free_at  <= 0;
      exp_q.delete();
    end else begin
      mblock_q <= block;
      if (edge_n >= free_at && !mblock_q && bus.new_data) begin
        exp_q.push_back({edge_n[31:0], bus.data});
        free_at <= edge_n + FRAME + 1;
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic         active = 1'b0;
  int           off = 0;
  int           k_edge;
  logic         bad = 1'b0;
  logic [10:0]  fb;
  logic [7:0]   cur;
  logic [W-1:0] e;
  logic         exp_busy;

  always @(negedge clk) begin
    exp_busy = (edge_n < free_at) || mblock_q;
    checks++;
    if (bus.busy !== exp_busy) begin
      errors++;
      $display("FAIL busy edge=%0d got=%b want=%b", edge_n, bus.busy, exp_busy);
    end
    if (rst) begin
      active = 1'b0;
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL tx_in_reset got=%b want=1", tx);
      end
    end else begin
      if (!active) begin
        if (tx === 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_start edge=%0d got=start want=idle", edge_n);
            cur = 8'h00;
          end else begin
            e = exp_q.pop_front();
            k_edge = int'(e[39:8]);
            cur = e[7:0];
            if (k_edge != edge_n - 1) begin
              errors++;
              $display("FAIL start_latency got_edge=%0d want_edge=%0d", edge_n - 1, k_edge);
            end
          end
          fb = '1;
          fb[0] = 1'b0;
          fb[8:1] = cur;
`ifdef AVR_UART_TX_PARITY_EN
          fb[9] = ^cur;
`endif
          active = 1'b1;
          off = 0;
          bad = 1'b0;
        end else if (tx !== 1'b1) begin
          checks++;
          errors++;
          $display("FAIL idle_level got=%b want=1", tx);
        end
      end
      if (active) begin
        if (tx !== fb[off / CPB]) bad = 1'b1;
        if (off % CPB == CPB - 1) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL frame_bit byte=%02h bit_time=%0d got_line_not_steady want=%b", cur, off / CPB, fb[off / CPB]);
          end
          bad = 1'b0;
        end
        off++;
        if (off == FRAME) begin
          active = 1'b0;
          frames_done++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_free();
    int n = 0;
    while (!(edge_n >= free_at && !mblock_q)) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL wait_free timeout got=busy want=idle");
        return;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wait_free();
    bus.data = b;
    bus.new_data = 1'b1;
    @(negedge clk);
    bus.new_data = 1'b0;
    bus.data = 8'($urandom);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    bus.data = b;
    bus.new_data = 1'b1;
    @(negedge clk);
    bus.new_data = 1'b0;
    bus.data = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (edge_n < free_at || active) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL wait_done timeout got=frame_running want=done");
        return;
      end
    end
  endtask

  task automatic wait_accept(input int prev);
    int n = 0;
    while (acc_cnt == prev) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL accept timeout got=none want=accepted");
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev;
    bus.data = 8'h00;
    bus.new_data = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(8'h55);
    wait_done();

    // Request while blocked is dropped; nothing must follow when block falls.
    block = 1'b1;
    repeat (2) @(negedge clk);
    pulse(8'hA3);
    repeat (500) @(negedge clk);
    block = 1'b0;
    repeat (50) @(negedge clk);
    send(8'hA3);
    wait_done();

    // Block rising mid-frame leaves the frame intact and holds busy afterwards.
    send(8'hFF);
    repeat (300) @(negedge clk);
    block = 1'b1;
    wait_done();
    repeat (200) @(negedge clk);
    block = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back with new_data held high.
    @(negedge clk);
    wait_free();
    prev = acc_cnt;
    bus.data = 8'h01;
    bus.new_data = 1'b1;
    wait_accept(prev);
    bus.data = 8'h80;
    prev = acc_cnt;
    wait_accept(prev);
    bus.new_data = 1'b0;
    wait_done();

    // Reset mid-frame: line returns high immediately.
    send(8'h00);
    repeat (449) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_async_reset got=%b want=1", tx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send(8'h07);
    wait_done();

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        block = 1'b1;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        block = 1'b0;
      end
      send(8'($urandom_range(0, 255)));
    end
    wait_done();
    repeat (10) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got_pending=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
